// File: rtl/gpr_bank.sv
// Storage array for a 16-entry general-purpose register file.
// It has one write port, all 16 entries driven in parallel, and a sequenced bulk clear.
module gpr_bank #(
  parameter int               WIDTH   = 16,
  parameter bit               R0_ZERO = 1'b1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [3:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_clr_req,
  output logic             o_wr_ack,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_q0,
  output logic [WIDTH-1:0] o_q1,
  output logic [WIDTH-1:0] o_q2,
  output logic [WIDTH-1:0] o_q3,
  output logic [WIDTH-1:0] o_q4,
  output logic [WIDTH-1:0] o_q5,
  output logic [WIDTH-1:0] o_q6,
  output logic [WIDTH-1:0] o_q7,
  output logic [WIDTH-1:0] o_q8,
  output logic [WIDTH-1:0] o_q9,
  output logic [WIDTH-1:0] o_q10,
  output logic [WIDTH-1:0] o_q11,
  output logic [WIDTH-1:0] o_q12,
  output logic [WIDTH-1:0] o_q13,
  output logic [WIDTH-1:0] o_q14,
  output logic [WIDTH-1:0] o_q15
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_next;
  logic             r_wr_ack;
  logic             w_wr_ack_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             w_wr_en;
  logic             w_clr_en;
  logic [WIDTH-1:0] w_q [16];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_wr_ack <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_wr_ack <= w_wr_ack_next;
      r_busy   <= w_busy_next;
    end
  end

  // A clear request in IDLE takes priority over a simultaneous write.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_wr_ack_next = 1'b0;
    w_busy_next   = r_busy;
    w_wr_en       = 1'b0;
    w_clr_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req) begin
          w_state_next = S_CLEAR;
          w_cnt_next   = 4'd0;
          w_busy_next  = 1'b1;
        end else if (i_we) begin
          w_wr_en       = 1'b1;
          w_wr_ack_next = 1'b1;
        end
      end
      S_CLEAR: begin
        w_clr_en   = 1'b1;
        w_cnt_next = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      if (gi == 0 && R0_ZERO) begin : g_zero
        assign w_q[gi] = '0;
      end else begin : g_rw
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge i_clk) begin
          if (i_rst) begin
            r_q <= '0;
          end else if (w_clr_en && r_cnt == 4'(gi)) begin
            r_q <= CLR_VAL;
          end else if (w_wr_en && i_waddr == 4'(gi)) begin
            r_q <= i_wdata;
          end
        end
        assign w_q[gi] = r_q;
      end
    end
  endgenerate

  assign o_wr_ack = r_wr_ack;
  assign o_busy   = r_busy;

  assign o_q0  = w_q[0];
  assign o_q1  = w_q[1];
  assign o_q2  = w_q[2];
  assign o_q3  = w_q[3];
  assign o_q4  = w_q[4];
  assign o_q5  = w_q[5];
  assign o_q6  = w_q[6];
  assign o_q7  = w_q[7];
  assign o_q8  = w_q[8];
  assign o_q9  = w_q[9];
  assign o_q10 = w_q[10];
  assign o_q11 = w_q[11];
  assign o_q12 = w_q[12];
  assign o_q13 = w_q[13];
  assign o_q14 = w_q[14];
  assign o_q15 = w_q[15];

endmodule

// File: tb/tb_gpr_bank.sv
// Directed plus random stimulus for gpr_bank, checked against a
// cycle-level register-file model kept in this bench.
module tb_gpr_bank;

  localparam logic [15:0] CLR = 16'h00A5;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_we = 1'b0;
  logic [3:0]  i_waddr = 4'd0;
  logic [15:0] i_wdata = 16'd0;
  logic        i_clr_req = 1'b0;
  logic        o_wr_ack;
  logic        o_busy;
  logic [15:0] q [16];

  int n_checks = 0;
  int n_pass   = 0;
  int n_steps  = 0;

  // Reference model: register contents, ack/busy flags, and the index of
  // the next register to clear (-1 when no clear is in progress).
  logic [15:0] m_q [16];
  logic        m_ack;
  logic        m_busy;
  int          m_clr_pos;

  always #5 clk = ~clk;

  gpr_bank #(.WIDTH(16), .R0_ZERO(1'b1), .CLR_VAL(CLR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_clr_req(i_clr_req),
    .o_wr_ack(o_wr_ack), .o_busy(o_busy),
    .o_q0(q[0]),   .o_q1(q[1]),   .o_q2(q[2]),   .o_q3(q[3]),
    .o_q4(q[4]),   .o_q5(q[5]),   .o_q6(q[6]),   .o_q7(q[7]),
    .o_q8(q[8]),   .o_q9(q[9]),   .o_q10(q[10]), .o_q11(q[11]),
    .o_q12(q[12]), .o_q13(q[13]), .o_q14(q[14]), .o_q15(q[15])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                            input logic clr, input logic rst);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_q[i] = 16'h0000;
      m_ack = 1'b0; m_busy = 1'b0; m_clr_pos = -1;
    end else if (m_clr_pos >= 0) begin
      if (m_clr_pos != 0) m_q[m_clr_pos] = CLR;
      m_ack = 1'b0;
      m_clr_pos++;
      if (m_clr_pos == 16) begin
        m_clr_pos = -1; m_busy = 1'b0;
      end
    end else if (clr) begin
      m_clr_pos = 0; m_busy = 1'b1; m_ack = 1'b0;
    end else if (we) begin
      if (wa != 4'd0) m_q[wa] = wd;
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
  endtask

  // Drive one cycle, advance the model, then compare every output.
  task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic clr, input logic rst);
    i_we = we; i_waddr = wa; i_wdata = wd; i_clr_req = clr; i_rst = rst;
    @(posedge clk);
    model_edge(we, wa, wd, clr, rst);
    #1;
    n_steps++;
    $display("step %0d rst=%b we=%b wa=%0d wd=%h clr=%b -> ack=%b busy=%b",
             n_steps, rst, we, wa, wd, clr, o_wr_ack, o_busy);
    check("wr_ack", {15'd0, o_wr_ack}, {15'd0, m_ack});
    check("busy", {15'd0, o_busy}, {15'd0, m_busy});
    for (int i = 0; i < 16; i++) check($sformatf("q%0d", i), q[i], m_q[i]);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cycles;
    for (int i = 0; i < 16; i++) m_q[i] = 16'hxxxx;
    m_ack = 1'b0; m_busy = 1'b0; m_clr_pos = -1;
    #1;

    // Reset held for two cycles.
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 4'd4, 16'h5555, 1'b1, 1'b1);
    idle();
    check("reset_busy", {15'd0, o_busy}, 16'd0);

    // Single write to R5.
    step(1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0);
    check("wr5_q5", q[5], 16'hBEEF);
    check("wr5_ack", {15'd0, o_wr_ack}, 16'd1);
    idle();
    check("wr5_ack_drop", {15'd0, o_wr_ack}, 16'd0);

    // Write to R0 is discarded but acknowledged.
    step(1'b1, 4'd0, 16'h1234, 1'b0, 1'b0);
    check("r0_q0", q[0], 16'h0000);
    check("r0_ack", {15'd0, o_wr_ack}, 16'd1);

    // Back-to-back writes, same target twice: later wins.
    step(1'b1, 4'd9, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 4'd9, 16'h2222, 1'b0, 1'b0);
    check("b2b_q9", q[9], 16'h2222);

    // Fill everything with FFFF, then bulk clear with writes during BUSY.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    busy_cycles = 0;
    for (int n = 0; n < 40 && o_busy; n++) begin
      busy_cycles++;
      step(1'b1, 4'($urandom_range(0, 15)), 16'(($urandom)), 1'($urandom_range(0, 1)), 1'b0);
      check("clr_no_ack", {15'd0, o_wr_ack}, 16'd0);
    end
    check("busy_len", 16'(busy_cycles), 16'd16);
    check("clr_q15", q[15], CLR);
    check("clr_q0", q[0], 16'h0000);

    // Write and clear in the same IDLE cycle: clear wins.
    step(1'b1, 4'd3, 16'h0001, 1'b1, 1'b0);
    check("wc_no_ack", {15'd0, o_wr_ack}, 16'd0);
    for (int n = 0; n < 16; n++) idle();
    check("wc_q3", q[3], CLR);
    check("wc_busy_done", {15'd0, o_busy}, 16'd0);

    // Reset on the 8th CLEAR cycle abandons the clear.
    for (int i = 1; i < 16; i++) step(1'b1, 4'(i), 16'hFFFF, 1'b0, 1'b0);
    step(1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    for (int n = 0; n < 7; n++) idle();
    step(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
    check("rc_busy", {15'd0, o_busy}, 16'd0);
    check("rc_q12", q[12], 16'h0000);
    step(1'b1, 4'd7, 16'hC0DE, 1'b0, 1'b0);
    check("rc_q7", q[7], 16'hC0DE);
    check("rc_ack", {15'd0, o_wr_ack}, 16'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
